// File: rtl/dm_bus_resp.sv
// Data-memory responder: word RAM behind a req/ack handshake with WAIT wait states and byte-lane writes.
// Optional out-of-range detection is enabled by defining DM_BOUND_CHK_EN.
module dm_bus_resp #(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 1024,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        be,
    output logic              ack,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH);
`ifdef DM_BOUND_CHK_EN
    localparam logic BOUND_CHK = 1'b1;
`else
    localparam logic BOUND_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              oor_q, oor_d;
    logic [31:0]       mem_q [DEPTH];

    logic [ADDR_W-1:0] acc_addr;
    logic              acc_we;
    logic              acc_oor;
    logic [IDX_W-1:0]  acc_idx;
    logic              enter_resp;

    // With WAIT==0 RESP is entered on the accept edge, before the latched copy exists.
    always_comb begin
        acc_addr = (state_q == S_IDLE) ? addr : addr_q;
        acc_we   = (state_q == S_IDLE) ? we   : we_q;
        acc_idx  = acc_addr[IDX_W-1:0];
        acc_oor  = BOUND_CHK && (32'(acc_addr) >= 32'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rdata_q <= 32'h0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            oor_q   <= oor_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = (WAIT == 0) ? S_RESP : S_WAIT;
                    cnt_d   = 4'd0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(WAIT - 1)) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rdata_d    = rdata_q;
        oor_d      = oor_q;
        enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
        if (state_q == S_IDLE && req) begin
            we_d    = we;
            addr_d  = addr;
            wdata_d = wdata;
            be_d    = be;
        end
        if (enter_resp) begin
            oor_d = acc_oor;
            if (acc_oor)     rdata_d = 32'hDEAD_BEEF;
            else if (!acc_we) rdata_d = mem_q[acc_idx];
        end
    end

    // Storage is never reset; the write commits on the RESP->IDLE edge so a reset aborts it.
    always_ff @(posedge clk) begin
        if (rst && state_q == S_RESP && we_q && !oor_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem_q[addr_q[IDX_W-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        ack   = (state_q == S_RESP);
        busy  = (state_q != S_IDLE);
        err   = ack && oor_q;
        rdata = rdata_q;
    end

endmodule

// File: tb/tb_dm_bus_resp.sv
// Scoreboard bench for dm_bus_resp: a WAIT=2 instance and a WAIT=0 instance share the write/address bus.
module tb_dm_bus_resp;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0, req0 = 1'b0;
    logic        we = 1'b0;
    logic [10:0] addr = '0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  be = 4'h0;
    logic        ack, busy, err, ack0, busy0, err0;
    logic [31:0] rdata, rdata0;

    always #5 clk = ~clk;

    dm_bus_resp #(.ADDR_W(11), .DEPTH(1024), .WAIT(2)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ack(ack), .rdata(rdata), .busy(busy), .err(err));

    dm_bus_resp #(.ADDR_W(11), .DEPTH(1024), .WAIT(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ack(ack0), .rdata(rdata0), .busy(busy0), .err(err0));

    typedef struct {logic [31:0] rdata; logic err;} exp_t;
    exp_t q2[$];
    exp_t q0[$];
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst && ack) begin
            if (q2.size() == 0) chk("unexpected ack", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = q2.pop_front();
                chk("rdata", rdata, e.rdata);
                chk("err", 32'(err), 32'(e.err));
                chk("busy at ack", 32'(busy), 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (rst && ack0) begin
            if (q0.size() == 0) chk("unexpected ack0", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = q0.pop_front();
                chk("rdata0", rdata0, e.rdata);
                chk("err0", 32'(err0), 32'(e.err));
            end
        end
    end

    // Issue one transaction at a negedge and wait (bounded) for its ack.
    task automatic op(input bit sel, input bit we_i, input logic [10:0] a, input logic [31:0] d,
                      input logic [3:0] b, input logic [31:0] exp_rd, input bit exp_err);
        int lat;
        bit got;
        exp_t e;
        e.rdata = exp_rd;
        e.err   = exp_err;
        if (sel) q0.push_back(e); else q2.push_back(e);
        we = we_i; addr = a; wdata = d; be = b;
        if (sel) req0 = 1'b1; else req = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (i == 0 && !sel) chk("busy after accept", 32'(busy), 32'd1);
            if (sel ? ack0 : ack) got = 1'b1;
        end
        chk("latency", got ? 32'(lat) : 32'd99, sel ? 32'd1 : 32'd3);
        req = 1'b0;
        req0 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int acks[$];
        exp_t e;
        // Reset with req asserted: nothing may be accepted.
        @(negedge clk);
        req = 1'b1; req0 = 1'b1; we = 1'b1; addr = 11'd1; wdata = 32'hFFFF_FFFF; be = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ack", 32'(ack), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst rdata", rdata, 32'h0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst ack0", 32'(ack0), 32'd0);
        req = 1'b0; req0 = 1'b0; rst = 1'b1;
        @(negedge clk);

        op(0, 1, 11'd5, 32'h1234_5678, 4'hF, 32'h0, 0);
        op(0, 0, 11'd5, 32'h0, 4'hF, 32'h1234_5678, 0);
        op(0, 1, 11'd7, 32'hAABB_CCDD, 4'hF, 32'h1234_5678, 0);
        op(0, 1, 11'd7, 32'h1122_3344, 4'b0101, 32'h1234_5678, 0);
        op(0, 0, 11'd7, 32'h0, 4'hF, 32'hAA22_CC44, 0);
        op(0, 1, 11'd7, 32'hFFFF_FFFF, 4'h0, 32'hAA22_CC44, 0);
        op(0, 0, 11'd7, 32'h0, 4'hF, 32'hAA22_CC44, 0);
        op(0, 1, 11'd6, 32'h6666_6666, 4'hF, 32'hAA22_CC44, 0);
        op(0, 1, 11'd9, 32'h0909_0909, 4'hF, 32'hAA22_CC44, 0);

        // Reset during the wait phase aborts the write to addr 9.
        we = 1'b1; addr = 11'd9; wdata = 32'hBAD0_BAD0; be = 4'hF; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("busy before abort", 32'(busy), 32'd1);
        rst = 1'b0; req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort ack", 32'(ack), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("abort rdata", rdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        op(0, 0, 11'd9, 32'h0, 4'hF, 32'h0909_0909, 0);

`ifdef DM_BOUND_CHK_EN
        op(0, 1, 11'd1030, 32'hCAFE_F00D, 4'hF, 32'hDEAD_BEEF, 1);
        op(0, 0, 11'd6, 32'h0, 4'hF, 32'h6666_6666, 0);
`else
        op(0, 1, 11'd1030, 32'hCAFE_F00D, 4'hF, 32'h0909_0909, 0);
        op(0, 0, 11'd6, 32'h0, 4'hF, 32'hCAFE_F00D, 0);
`endif

        // WAIT=0: single op, then a held read request yields acks at edges N+1 and N+3.
        op(1, 1, 11'd3, 32'h0000_0033, 4'hF, 32'h0, 0);
        e.rdata = 32'h0000_0033;
        e.err = 1'b0;
        q0.push_back(e);
        q0.push_back(e);
        we = 1'b0; addr = 11'd3; req0 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack0) acks.push_back(i);
            if (acks.size() == 2) break;
        end
        req0 = 1'b0;
        chk("held ack count", 32'(acks.size()), 32'd2);
        if (acks.size() == 2) begin
            chk("held first ack", 32'(acks[0]), 32'd1);
            chk("held second ack", 32'(acks[1]), 32'd3);
        end
        repeat (3) @(negedge clk);

        chk("q2 drained", 32'(q2.size()), 32'd0);
        chk("q0 drained", 32'(q0.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
